// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency SRAM between instruction fetch (IF)
// and the MEM-stage load/store port. Each access holds the SRAM pins for
// WAIT_CYCLES cycles, then a one-cycle RESP state pulses the granted ready.
// Simultaneous requests from IDLE alternate between the two requesters.
module mem_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_CYCLES     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  // instruction fetch port
  input  logic                       if_req,
  input  logic [31:0]                if_addr,
  output logic [DATA_WIDTH-1:0]      if_rdata,
  output logic                       if_ready,
  // MEM-stage load/store port
  input  logic                       mem_r_en,
  input  logic                       mem_w_en,
  input  logic [31:0]                mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       mem_ready,
  // pipeline freeze
  output logic                       if_stall,
  output logic                       mem_stall,
  // external SRAM
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  output logic                       sram_drive,
  input  logic [DATA_WIDTH-1:0]      sram_rdata,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DATA_ACC = 2'd1;
  localparam logic [1:0] INST_ACC = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  localparam logic GNT_DATA = 1'b0;
  localparam logic GNT_INST = 1'b1;

  // A one-cycle access still needs a one-bit counter.
  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]                 state;
  logic [CNT_W-1:0]           cnt;
  logic                       gnt;
  logic                       last_grant;
  logic                       wr;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;

  logic dreq;
  logic pick_data;
  logic in_acc;

  // Only the word-address bits reach the SRAM; byte offset and high bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:SRAM_ADDR_WIDTH+2], if_addr[1:0],
                              mem_addr[31:SRAM_ADDR_WIDTH+2], mem_addr[1:0]};

  // Grant choice: DATA wins unless IF is also asking and DATA had the last grant.
  assign dreq      = mem_r_en | mem_w_en;
  assign pick_data = dreq & (~if_req | (last_grant == GNT_INST));
  assign in_acc    = (state == DATA_ACC) || (state == INST_ACC);

  // Access sequencer: grant in IDLE, hold pins WAIT_CYCLES cycles, pulse ready in RESP.
  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= GNT_INST;
      last_grant <= GNT_INST;
      wr         <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq || if_req) begin
            cnt     <= '0;
            wdata_q <= mem_wdata;
            // A simultaneous read+write request is performed as a write.
            wr      <= pick_data & mem_w_en;
            if (pick_data) begin
              state      <= DATA_ACC;
              gnt        <= GNT_DATA;
              last_grant <= GNT_DATA;
              addr_q     <= mem_addr[SRAM_ADDR_WIDTH+1:2];
            end else begin
              state      <= INST_ACC;
              gnt        <= GNT_INST;
              last_grant <= GNT_INST;
              addr_q     <= if_addr[SRAM_ADDR_WIDTH+1:2];
            end
          end
        end
        DATA_ACC, INST_ACC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= RESP;
            if (!wr) begin
              if (gnt == GNT_INST) if_rdata  <= sram_rdata;
              else                 mem_rdata <= sram_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Ready pulses and SRAM pins decode directly from state, so a reset drops them next cycle.
  assign if_ready  = (state == RESP) && (gnt == GNT_INST);
  assign mem_ready = (state == RESP) && (gnt == GNT_DATA);

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = dreq & ~mem_ready;

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_drive = in_acc & wr;
  assign sram_we_n  = ~(in_acc & wr);
  assign sram_oe_n  = ~(in_acc & ~wr);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A WAIT_CYCLES=3 instance is
// driven through a scoreboard (expected ready owner, cycle and data pushed
// at request time, popped when a ready pulse appears); a WAIT_CYCLES=1
// instance covers the short-latency build and the read+write collision.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int W  = 3;

  typedef struct {
    logic        is_if;
    logic [31:0] data;
    int          due;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (W=3)
  logic          if_req, mem_r_en, mem_w_en;
  logic [31:0]   if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic          if_ready, mem_ready, if_stall, mem_stall;
  logic [AW-1:0] sram_addr;
  logic          sram_drive, sram_we_n, sram_oe_n;

  // short-latency instance (W=1)
  logic          w1_if_req, w1_mem_r_en, w1_mem_w_en;
  logic [31:0]   w1_if_addr, w1_mem_addr;
  logic [DW-1:0] w1_mem_wdata, w1_if_rdata, w1_mem_rdata, w1_sram_wdata, w1_sram_rdata;
  logic          w1_if_ready, w1_mem_ready, w1_if_stall, w1_mem_stall;
  logic [AW-1:0] w1_sram_addr;
  logic          w1_sram_drive, w1_sram_we_n, w1_sram_oe_n;

  mem_port_arbiter #(.DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  mem_port_arbiter #(.DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ready(w1_if_ready),
    .mem_r_en(w1_mem_r_en), .mem_w_en(w1_mem_w_en), .mem_addr(w1_mem_addr),
    .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready),
    .if_stall(w1_if_stall), .mem_stall(w1_mem_stall),
    .sram_addr(w1_sram_addr), .sram_wdata(w1_sram_wdata), .sram_drive(w1_sram_drive),
    .sram_rdata(w1_sram_rdata), .sram_we_n(w1_sram_we_n), .sram_oe_n(w1_sram_oe_n)
  );

  // Shared SRAM model: reads return data only while output enable is asserted.
  logic [31:0] sram_mem [0:255];
  always @(posedge clk) begin
    if (!sram_we_n && sram_drive)       sram_mem[sram_addr[7:0]]    <= sram_wdata;
    if (!w1_sram_we_n && w1_sram_drive) sram_mem[w1_sram_addr[7:0]] <= w1_sram_wdata;
  end
  assign sram_rdata    = sram_oe_n    ? '0 : sram_mem[sram_addr[7:0]];
  assign w1_sram_rdata = w1_sram_oe_n ? '0 : sram_mem[w1_sram_addr[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sb_entry_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic is_if, input logic [31:0] data, input int due);
    sb_entry_t e;
    e.is_if = is_if;
    e.data  = data;
    e.due   = due;
    sb.push_back(e);
  endtask

  function automatic bit more_of(input logic k);
    foreach (sb[i]) if (sb[i].is_if == k) return 1'b1;
    return 1'b0;
  endfunction

  // Called at each falling edge: match any ready pulse against the scoreboard head.
  task automatic observe();
    sb_entry_t e;
    if (mem_ready === 1'b1 || if_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'({if_ready, mem_ready}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("both_ready", 32'(if_ready & mem_ready), 32'd0);
        check("ready_who", 32'(if_ready), 32'(e.is_if));
        check("ready_cycle", cyc, e.due);
        if (e.is_if) begin
          check("if_rdata", if_rdata, e.data);
          check("if_stall_at_ready", 32'(if_stall), 32'd0);
          if (!more_of(1'b1)) if_req = 1'b0;
        end else begin
          check("mem_rdata", mem_rdata, e.data);
          check("mem_stall_at_ready", 32'(mem_stall), 32'd0);
          if (!more_of(1'b0)) begin
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  // Run until the scoreboard empties; stalls must be high while a request waits.
  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (sb.size() > 0 && n < limit) begin
      step();
      if (if_req && !if_ready) check({tag, "_if_stall"}, 32'(if_stall), 32'd1);
      if ((mem_r_en || mem_w_en) && !mem_ready) check({tag, "_mem_stall"}, 32'(mem_stall), 32'd1);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
      if_req   = 1'b0;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0100_0000 + i;
    sram_mem[4]  = 32'hDEAD_BEEF;
    sram_mem[16] = 32'hCAFE_F00D;
    sram_mem[17] = 32'h3333_4444;
    sram_mem[20] = 32'h0BAD_C0DE;
    sram_mem[21] = 32'h1111_2222;
    sram_mem[24] = 32'hA5A5_5A5A;

    rst = 1'b1;
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    w1_if_req = 1'b0; w1_mem_r_en = 1'b0; w1_mem_w_en = 1'b0;
    w1_if_addr = '0; w1_mem_addr = '0; w1_mem_wdata = '0;

    // ---- reset state ----
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_drive", 32'(sram_drive), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_w1_oe_n", 32'(w1_sram_oe_n), 32'd1);
    check("rst_w1_ready", 32'(w1_mem_ready), 32'd0);
    if_req = 1'b1; mem_w_en = 1'b1;
    #1;
    check("stall_if_tracks", 32'(if_stall), 32'd1);
    check("stall_mem_tracks", 32'(mem_stall), 32'd1);
    if_req = 1'b0; mem_w_en = 1'b0;
    #1;
    check("stall_if_idle", 32'(if_stall), 32'd0);
    check("stall_mem_idle", 32'(mem_stall), 32'd0);
    step();
    step();

    // ---- single load ----
    mem_addr = 32'h0000_0010;
    mem_r_en = 1'b1;
    push(1'b0, 32'hDEAD_BEEF, cyc + 1 + W);
    for (int k = 1; k <= W; k++) begin
      step();
      check("ld_sram_addr", 32'(sram_addr), 32'd4);
      check("ld_oe_n", 32'(sram_oe_n), 32'd0);
      check("ld_we_n", 32'(sram_we_n), 32'd1);
      check("ld_drive", 32'(sram_drive), 32'd0);
      check("ld_stall", 32'(mem_stall), 32'd1);
    end
    drain("ld", 4);
    check("ld_oe_n_resp", 32'(sram_oe_n), 32'd1);
    step();

    // ---- single store; inputs change after grant ----
    mem_addr  = 32'h0000_0020;
    mem_wdata = 32'h1234_5678;
    mem_w_en  = 1'b1;
    push(1'b0, 32'hDEAD_BEEF, cyc + 1 + W);
    for (int k = 1; k <= W; k++) begin
      step();
      if (k == 1) begin
        mem_addr  = 32'h0000_0FFC;
        mem_wdata = 32'hFFFF_FFFF;
      end
      check("st_sram_addr", 32'(sram_addr), 32'd8);
      check("st_sram_wdata", sram_wdata, 32'h1234_5678);
      check("st_we_n", 32'(sram_we_n), 32'd0);
      check("st_drive", 32'(sram_drive), 32'd1);
      check("st_oe_n", 32'(sram_oe_n), 32'd1);
    end
    drain("st", 4);
    check("st_we_n_resp", 32'(sram_we_n), 32'd1);
    step();
    check("st_sram_content", sram_mem[8], 32'h1234_5678);

    // ---- reset in cycle 2 of a read aborts it ----
    mem_addr = 32'h0000_0030;
    mem_r_en = 1'b1;
    step();
    check("abort_started", 32'(sram_oe_n), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("abort_oe_n", 32'(sram_oe_n), 32'd1);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    mem_r_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_ready", 32'(mem_ready), 32'd0);
    end

    // ---- tie after reset: DATA first, IF after the IDLE turnaround ----
    if_addr  = 32'h0000_0040;
    mem_addr = 32'h0000_0050;
    if_req   = 1'b1;
    mem_r_en = 1'b1;
    push(1'b0, 32'h0BAD_C0DE, cyc + 1 + W);
    push(1'b1, 32'hCAFE_F00D, cyc + 1 + W + (W + 2));
    drain("tie", 20);
    step();

    // ---- round-robin with both requesters held ----
    if_addr  = 32'h0000_0044;
    mem_addr = 32'h0000_0054;
    if_req   = 1'b1;
    mem_r_en = 1'b1;
    begin
      int c0;
      c0 = cyc;
      for (int k = 0; k < 4; k++)
        push(k[0], k[0] ? 32'h3333_4444 : 32'h1111_2222, c0 + 1 + W + k * (W + 2));
    end
    drain("rr", 40);
    step();
    check("rr_if_rdata_hold", if_rdata, 32'h3333_4444);
    check("rr_mem_rdata_hold", mem_rdata, 32'h1111_2222);

    // ---- WAIT_CYCLES=1 build ----
    w1_mem_addr = 32'h0000_0060;
    w1_mem_r_en = 1'b1;
    step();
    check("w1_ld_oe_n", 32'(w1_sram_oe_n), 32'd0);
    check("w1_ld_addr", 32'(w1_sram_addr), 32'd24);
    check("w1_ld_no_ready", 32'(w1_mem_ready), 32'd0);
    check("w1_ld_stall", 32'(w1_mem_stall), 32'd1);
    step();
    check("w1_ld_ready", 32'(w1_mem_ready), 32'd1);
    check("w1_ld_rdata", w1_mem_rdata, 32'hA5A5_5A5A);
    check("w1_ld_stall_rdy", 32'(w1_mem_stall), 32'd0);
    check("w1_ld_oe_n_resp", 32'(w1_sram_oe_n), 32'd1);
    w1_mem_r_en = 1'b0;
    step();
    w1_mem_addr  = 32'h0000_0064;
    w1_mem_wdata = 32'h600D_D00D;
    w1_mem_r_en  = 1'b1;
    w1_mem_w_en  = 1'b1;
    step();
    check("w1_rw_we_n", 32'(w1_sram_we_n), 32'd0);
    check("w1_rw_drive", 32'(w1_sram_drive), 32'd1);
    check("w1_rw_oe_n", 32'(w1_sram_oe_n), 32'd1);
    check("w1_rw_addr", 32'(w1_sram_addr), 32'd25);
    step();
    check("w1_rw_ready", 32'(w1_mem_ready), 32'd1);
    check("w1_rw_rdata_kept", w1_mem_rdata, 32'hA5A5_5A5A);
    w1_mem_r_en = 1'b0;
    w1_mem_w_en = 1'b0;
    step();
    check("w1_rw_sram_content", sram_mem[25], 32'h600D_D00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency external SRAM between two requesters: instruction fetch (IF) and the MEM stage's load/store.
- MEM_R_EN / MEM_W_EN come from the decode controller through the pipeline registers.
- Sequences each access over WAIT_CYCLES cycles and returns a one-cycle ready pulse to the granted requester.
- Produces the stall signals the pipeline uses to freeze while an access is pending.

Parameters:
- DATA_WIDTH, 32, requester and SRAM data width.
- SRAM_ADDR_WIDTH, 18, SRAM word-address width.
- WAIT_CYCLES, 3, cycles each access holds the SRAM pins; legal values are 1 and above.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held high until if_ready.
- if_addr  in  32  IF byte address.
- if_rdata  out  DATA_WIDTH  fetched instruction, registered.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_r_en  in  1  MEM-stage load request.
- mem_w_en  in  1  MEM-stage store request.
- mem_addr  in  32  MEM-stage byte address.
- mem_wdata  in  DATA_WIDTH  store data.
- mem_rdata  out  DATA_WIDTH  load data, registered.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- if_stall  out  1  if_req & ~if_ready; combinational.
- mem_stall  out  1  (mem_r_en | mem_w_en) & ~mem_ready; combinational.
- sram_addr  out  SRAM_ADDR_WIDTH  word address = addr[SRAM_ADDR_WIDTH+1:2].
- sram_wdata  out  DATA_WIDTH  write data.
- sram_drive  out  1  data-bus drive enable; high only during write access.
- sram_rdata  in  DATA_WIDTH  read data; valid in the last access cycle.
- sram_we_n  out  1  write enable, active low.
- sram_oe_n  out  1  output enable, active low.

Behaviour:

Reset (rst=1 at an edge):
- state=IDLE, cnt=0, last_grant=INST, if_rdata=0, mem_rdata=0.
- if_ready=0, mem_ready=0.
- sram_we_n=1, sram_oe_n=1, sram_drive=0, sram_addr=0, sram_wdata=0.
- Reset mid-access aborts the access: no ready pulse, and pins are inactive from the next cycle.

States: IDLE, DATA_ACC, INST_ACC, RESP. Registered fields: cnt, gnt (DATA/INST), wr flag, latched address, latched wdata.

IDLE, sampled at the edge:
- dreq = mem_r_en | mem_w_en.
- dreq & if_req: grant the requester not in last_grant (round-robin); reset leaves last_grant=INST, so the first tie goes to DATA.
- dreq only: DATA_ACC.
- if_req only: INST_ACC.
- No request: stay in IDLE.
- On grant: latch address, wdata and wr = mem_w_en; set cnt=0; set last_grant=gnt.
- mem_r_en & mem_w_en together is illegal; it is treated as a write.

DATA_ACC / INST_ACC:
- Pins are driven from the latched values for exactly WAIT_CYCLES cycles.
- Write: sram_we_n=0 and sram_drive=1 for all access cycles.
- Read: sram_oe_n=0 for all access cycles.
- cnt increments each cycle.
- When cnt==WAIT_CYCLES-1: on a read, capture sram_rdata into if_rdata or mem_rdata per gnt, then go to RESP.

RESP:
- Pins inactive.
- Exactly one of if_ready / mem_ready is high, per gnt.
- Next state is IDLE.

Timing and data rules:
- Latency: request first sampled at edge 0 gives ready high in cycle WAIT_CYCLES+1. With W=3, ready is in cycle 4.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Requester inputs may change after grant; the latched values are used.
- A requester must hold its request until ready. If it drops mid-access, the access still completes and ready still pulses.
- Stores leave mem_rdata unchanged.
- if_rdata and mem_rdata hold their values until the next capture for the same requester.
- Stalls deassert in the ready cycle, so the pipeline advances on that edge. A request still high in the ready cycle is not a new request; IDLE samples again on the following edge.

Test Plan:
- Reset: after rst, all pins inactive, readys 0, stalls track inputs. Assert rst in cycle 2 of a read → no ready pulse; state returns to IDLE.
- Single load: mem_r_en=1, mem_addr=0x0000_0010, sram_rdata=0xDEAD_BEEF → sram_addr=4 and sram_oe_n=0 for cycles 1–3; mem_ready=1 in cycle 4; mem_rdata=0xDEAD_BEEF; mem_stall=0 in cycle 4.
- Single store: mem_w_en=1, addr=0x20, wdata=0x1234_5678 → sram_we_n=0 and sram_drive=1 for 3 cycles at sram_addr=8; mem_ready in cycle 4; mem_rdata unchanged.
- Tie after reset: if_req and mem_r_en high at edge 0 → DATA first, with mem_ready in cycle 4. IF is then granted (turnaround via IDLE), with if_ready in cycle 9 and if_stall high until then.
- Round-robin: both requesters held continuously, with readys observed → grants alternate DATA, INST, DATA, INST; neither requester gets two grants in a row.
- WAIT_CYCLES=1 build: a lone read gives ready in cycle 2; mem_r_en & mem_w_en together is performed as a write.
